// File: rtl/rx_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_assembler
// Description : Packs SYMBOL_WIDTH-bit symbols into WORD_WIDTH-bit words and
//               presents them in a single-entry valid/ready output slot.
//               Optional inter-symbol timeout enabled by RX_ASM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_word_assembler #(
  parameter int SYMBOL_WIDTH   = 8,
  parameter int WORD_WIDTH     = 32,
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int NUM_SYMS      = WORD_WIDTH / SYMBOL_WIDTH,
  localparam int CNT_W         = $clog2(NUM_SYMS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_sym_valid,
  input  logic [SYMBOL_WIDTH-1:0] i_sym_data,
  input  logic                    i_flush,
  input  logic                    i_word_ready,
  input  logic                    i_clear_err,
  output logic [WORD_WIDTH-1:0]   o_word,
  output logic                    o_word_valid,
  output logic [CNT_W-1:0]        o_sym_count,
  output logic                    o_busy,
  output logic                    o_overflow,
  output logic                    o_timeout
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_next_count;
  logic [WORD_WIDTH-1:0]   r_partial;
  logic [WORD_WIDTH-1:0]   w_next_partial;
  logic [WORD_WIDTH-1:0]   w_assembled;
  logic [WORD_WIDTH-1:0]   r_word;
  logic                    r_word_valid;
  logic                    r_overflow;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_complete;
  logic                    w_slot_free;
  logic                    w_timeout_hit;

  if ((WORD_WIDTH % SYMBOL_WIDTH) != 0 || NUM_SYMS < 1) begin : g_bad_width
    $error("rx_word_assembler: WORD_WIDTH must be a non-zero multiple of SYMBOL_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rx_word_assembler: TIMEOUT_CYCLES must be at least 1");
  end

  // The symbol in flight is merged into its slot so a completing word is
  // available in the same cycle as its last strobe.
  for (genvar k = 0; k < NUM_SYMS; k++) begin : g_slot
    localparam int POS = (MSB_FIRST != 0) ? (NUM_SYMS - 1 - k) : k;
    assign w_assembled[POS*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
      (r_count == CNT_W'(k)) ? i_sym_data
                             : r_partial[POS*SYMBOL_WIDTH +: SYMBOL_WIDTH];
  end

  assign w_accept    = i_sym_valid && !i_flush;
  assign w_last      = (r_count == CNT_W'(NUM_SYMS - 1));
  assign w_complete  = w_accept && w_last;
  assign w_slot_free = !r_word_valid || i_word_ready;

  always_comb begin
    w_next_count   = r_count;
    w_next_partial = r_partial;
    if (i_flush || w_timeout_hit || w_complete) begin
      w_next_count   = '0;
      w_next_partial = '0;
    end else if (w_accept) begin
      w_next_count   = r_count + CNT_W'(1);
      w_next_partial = w_assembled;
    end
    w_next_state = (w_next_count != '0) ? ST_COLLECT : ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_partial <= '0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_partial <= w_next_partial;
    end
  end

  // A set event outranks a same-cycle clear so no drop goes unreported.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_complete && w_slot_free) begin
        r_word       <= w_assembled;
        r_word_valid <= 1'b1;
      end else if (r_word_valid && i_word_ready) begin
        r_word_valid <= 1'b0;
      end
      if (w_complete && !w_slot_free) begin
        r_overflow <= 1'b1;
      end else if (i_clear_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef RX_ASM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_idle;
  logic            r_timeout;

  // An arriving symbol always beats the timeout in the same cycle.
  assign w_timeout_hit = (r_state == ST_COLLECT) && !i_sym_valid && !i_flush &&
                         (r_idle == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      if (r_state == ST_IDLE || i_sym_valid || i_flush || w_timeout_hit) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + TO_W'(1);
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_sym_count  = r_count;
  assign o_busy       = (r_state == ST_COLLECT);
  assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rx_word_assembler.sv
`default_nettype none
// Testbench for rx_word_assembler: LSB-first and MSB-first instances driven in
// lockstep and compared each cycle against a queue-based reference model.
module tb_rx_word_assembler;

`ifdef RX_ASM_TIMEOUT_EN
  localparam bit TO_EN       = 1'b1;
  localparam int EXP_PULSES  = 1;
  localparam int EXP_CNT_TO  = 0;
`else
  localparam bit TO_EN       = 1'b0;
  localparam int EXP_PULSES  = 0;
  localparam int EXP_CNT_TO  = 1;
`endif
  localparam int TO_CYC = 16;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_sym_valid;
  logic [7:0]  i_sym_data;
  logic        i_flush;
  logic        i_word_ready;
  logic        i_clear_err;

  logic [31:0] word_l, word_m;
  logic        valid_l, valid_m, busy_l, busy_m, ovf_l, ovf_m, to_l, to_m;
  logic [2:0]  cnt_l, cnt_m;

  rx_word_assembler #(.MSB_FIRST(0), .TIMEOUT_CYCLES(TO_CYC)) dut_lsb (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sym_valid(i_sym_valid),
    .i_sym_data(i_sym_data), .i_flush(i_flush), .i_word_ready(i_word_ready),
    .i_clear_err(i_clear_err), .o_word(word_l), .o_word_valid(valid_l),
    .o_sym_count(cnt_l), .o_busy(busy_l), .o_overflow(ovf_l), .o_timeout(to_l));

  rx_word_assembler #(.MSB_FIRST(1), .TIMEOUT_CYCLES(TO_CYC)) dut_msb (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sym_valid(i_sym_valid),
    .i_sym_data(i_sym_data), .i_flush(i_flush), .i_word_ready(i_word_ready),
    .i_clear_err(i_clear_err), .o_word(word_m), .o_word_valid(valid_m),
    .o_sym_count(cnt_m), .o_busy(busy_m), .o_overflow(ovf_m), .o_timeout(to_m));

  always #5 i_clk = ~i_clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  q[$];
  logic [31:0] m_word_l, m_word_m;
  bit          m_valid, m_ovf, m_to;
  int          m_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_word_l = '0; m_word_m = '0;
    m_valid = 0; m_ovf = 0; m_to = 0; m_idle = 0;
  endtask

  task automatic check_all();
    chk("word_lsb",  word_l, m_word_l);
    chk("word_msb",  word_m, m_word_m);
    chk("valid_lsb", {31'b0, valid_l}, {31'b0, m_valid});
    chk("valid_msb", {31'b0, valid_m}, {31'b0, m_valid});
    chk("count_lsb", {29'b0, cnt_l}, 32'(q.size()));
    chk("count_msb", {29'b0, cnt_m}, 32'(q.size()));
    chk("busy_lsb",  {31'b0, busy_l}, {31'b0, (q.size() != 0)});
    chk("ovf_lsb",   {31'b0, ovf_l}, {31'b0, m_ovf});
    chk("ovf_msb",   {31'b0, ovf_m}, {31'b0, m_ovf});
    chk("tout_lsb",  {31'b0, to_l}, {31'b0, m_to});
    chk("tout_msb",  {31'b0, to_m}, {31'b0, m_to});
  endtask

  // Drives one cycle of inputs, advances the model, checks after the edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit fl,
                       input bit rdy, input bit clr);
    bit          comp, free, to_now;
    logic [31:0] wl, wm;
    i_sym_valid = v; i_sym_data = d; i_flush = fl;
    i_word_ready = rdy; i_clear_err = clr;
    comp = 0; to_now = 0; wl = '0; wm = '0;
    free = !m_valid || rdy;
    if (fl) begin
      q.delete(); m_idle = 0;
    end else if (v) begin
      q.push_back(d); m_idle = 0;
      if (q.size() == 4) begin
        foreach (q[i]) begin
          wl |= 32'(q[i]) << (8 * i);
          wm |= 32'(q[i]) << (8 * (3 - i));
        end
        comp = 1;
        q.delete();
      end
    end else if (q.size() != 0) begin
      m_idle++;
      if (TO_EN && m_idle == TO_CYC) begin
        q.delete(); m_idle = 0; to_now = 1;
      end
    end
    m_to = to_now;
    if (comp) begin
      if (free) begin m_word_l = wl; m_word_m = wm; m_valid = 1; end
      else m_ovf = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (clr && !(comp && !free)) m_ovf = 0;
    @(posedge i_clk); #1;
    check_all();
  endtask

  initial begin
    int pulses;
    i_reset_n = 1'b0; i_sym_valid = 0; i_sym_data = '0; i_flush = 0;
    i_word_ready = 0; i_clear_err = 0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_all();
    i_reset_n = 1'b1;

    // Basic packing with consumer always ready
    cycle(1, 8'h11, 0, 1, 0); cycle(1, 8'h22, 0, 1, 0);
    cycle(1, 8'h33, 0, 1, 0); cycle(1, 8'h44, 0, 1, 0);
    chk("t1_word_lsb", word_l, 32'h44332211);
    chk("t1_word_msb", word_m, 32'h11223344);
    chk("t1_valid", {31'b0, valid_l}, 32'd1);
    cycle(0, 8'h00, 0, 1, 0);
    chk("t1_valid_clr", {31'b0, valid_l}, 32'd0);

    // Overflow with stalled consumer, then clear
    for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 0, 0);
    chk("t3_word_held", word_l, 32'h04030201);
    chk("t3_ovf", {31'b0, ovf_l}, 32'd1);
    cycle(0, 8'h00, 0, 0, 1);
    chk("t3_ovf_clr", {31'b0, ovf_l}, 32'd0);
    cycle(0, 8'h00, 0, 1, 0);

    // Flush discards partial content
    cycle(1, 8'hAA, 0, 1, 0); cycle(1, 8'hBB, 0, 1, 0);
    cycle(0, 8'h00, 1, 1, 0);
    chk("t4_busy_after_flush", {31'b0, busy_l}, 32'd0);
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1, 0);
    chk("t4_word", word_l, 32'h04030201);
    cycle(0, 8'h00, 0, 1, 0);

    // Completion coincident with handshake on a full slot
    for (int i = 5; i <= 8; i++) cycle(1, 8'(i), 0, 0, 0);
    chk("t5_first", word_l, 32'h08070605);
    cycle(1, 8'h09, 0, 0, 0); cycle(1, 8'h0A, 0, 0, 0); cycle(1, 8'h0B, 0, 0, 0);
    cycle(1, 8'h0C, 0, 1, 0);
    chk("t5_second", word_l, 32'h0C0B0A09);
    chk("t5_valid", {31'b0, valid_l}, 32'd1);
    chk("t5_ovf", {31'b0, ovf_l}, 32'd0);

    // Asynchronous reset mid-word
    cycle(1, 8'h55, 0, 0, 0); cycle(1, 8'h66, 0, 0, 0);
    i_sym_valid = 0; i_word_ready = 0;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_word", word_l, 32'h0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 8'h21 + 8'(i), 0, 1, 0);
    chk("rst_clean_word", word_l, 32'h24232221);

    // Inter-symbol timeout
    pulses = 0;
    cycle(1, 8'h5A, 0, 1, 0);
    for (int i = 0; i < TO_CYC + 1; i++) begin
      cycle(0, 8'h00, 0, 1, 0);
      pulses += int'(to_l);
    end
    chk("to_pulses", 32'(pulses), 32'(EXP_PULSES));
    chk("to_count", {29'b0, cnt_l}, 32'(EXP_CNT_TO));
    cycle(0, 8'h00, 1, 1, 0);
    pulses = 0;
    cycle(1, 8'h5B, 0, 1, 0);
    for (int i = 0; i < TO_CYC - 1; i++) begin
      cycle(0, 8'h00, 0, 1, 0);
      pulses += int'(to_l);
    end
    cycle(1, 8'h5C, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 0, 1, 0);
      pulses += int'(to_l);
    end
    chk("to_none", 32'(pulses), 32'd0);
    chk("to_none_count", {29'b0, cnt_l}, 32'd2);
    cycle(0, 8'h00, 1, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 3) != 0, 8'($urandom), ($urandom % 20) == 0,
            ($urandom % 2) == 0, ($urandom % 10) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
- Parametrised successor to the bit-serial instruction receiver.
- Packs a stream of SYMBOL_WIDTH-bit symbols (typically UART bytes) into WORD_WIDTH-bit instruction/command words.
- Packing order is selectable.
- Presents each completed word in a single-entry output slot with a valid/ready handshake, plus flush, sticky overflow and optional inter-symbol timeout.
- Sits between the UART receiver and the debug-unit command decoder.

Parameters:
- SYMBOL_WIDTH, 8, bits per incoming symbol.
- WORD_WIDTH, 32, bits per assembled word; must be an integer multiple of SYMBOL_WIDTH.
- MSB_FIRST, 0, 0 = first symbol lands in bits [SYMBOL_WIDTH-1:0]; 1 = first symbol lands in the top symbol slot.
- TIMEOUT_CYCLES, 1000, idle cycles allowed between symbols of a partial word (used only with RX_ASM_TIMEOUT_EN).
- Derived localparams: NUM_SYMS = WORD_WIDTH/SYMBOL_WIDTH; CNT_W = $clog2(NUM_SYMS+1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_sym_valid  in  1  single-cycle strobe; i_sym_data is valid this cycle.
- i_sym_data  in  SYMBOL_WIDTH  incoming symbol.
- i_flush  in  1  discard the partial word.
- i_word_ready  in  1  consumer accepts o_word this cycle.
- i_clear_err  in  1  clear o_overflow.
- o_word  out  WORD_WIDTH  assembled word; stable while o_word_valid=1.
- o_word_valid  out  1  output slot full.
- o_sym_count  out  CNT_W  symbols held in the current partial word (0..NUM_SYMS-1).
- o_busy  out  1  o_sym_count != 0.
- o_overflow  out  1  sticky: a completed word was dropped.
- o_timeout  out  1  one-cycle pulse: partial word discarded by timeout.

Behaviour:
- Reset (i_reset_n=0, async):
  - All outputs and internal registers go to 0: o_word=0, o_word_valid=0, o_sym_count=0, o_overflow=0, o_timeout=0.
  - A partial word is lost.
- Symbol accept:
  - When i_sym_valid=1 and i_flush=0, the symbol is written into slot o_sym_count.
  - LSB-first (MSB_FIRST=0): slot k occupies bits [k*SYMBOL_WIDTH +: SYMBOL_WIDTH].
  - MSB-first (MSB_FIRST=1): slot k occupies bits [(NUM_SYMS-1-k)*SYMBOL_WIDTH +: SYMBOL_WIDTH].
  - o_sym_count increments.
- Completion (accepted symbol has o_sym_count == NUM_SYMS-1):
  - The assembled word, including the current symbol, is formed combinationally.
  - The slot counts as free if o_word_valid=0, or if o_word_valid=1 and i_word_ready=1 in the same cycle.
  - Slot free: o_word is loaded and o_word_valid=1 on the next edge. Latency is 1 cycle from the last strobe.
  - Slot not free: the new word is dropped, o_word is unchanged, and o_overflow is set.
  - In both cases o_sym_count wraps to 0 and the partial register clears.
- Handshake:
  - o_word_valid && i_word_ready with no simultaneous completion: o_word_valid goes to 0 on the next edge.
  - o_word retains its last value; it is not cleared.
  - i_word_ready while o_word_valid=0 is ignored.
- Back-to-back symbols every cycle are supported. No throughput loss while the consumer accepts within NUM_SYMS cycles.
- Flush:
  - i_flush=1 sets o_sym_count=0 and clears the partial register.
  - The output slot and o_overflow are untouched.
  - Flush and i_sym_valid in the same cycle: flush wins and the symbol is dropped, even if it would have completed a word.
- Overflow clear:
  - i_clear_err=1 clears o_overflow.
  - A same-cycle overflow event wins, so o_overflow stays 1.
- Two-state view: IDLE (count=0) / COLLECT (count>0); o_busy=1 in COLLECT. The output slot is an independent full/empty flag.

Optional Feature:
- Macro: RX_ASM_TIMEOUT_EN.
- Defined:
  - An idle counter runs while o_busy=1; it resets on every accepted symbol and on flush.
  - When it reaches TIMEOUT_CYCLES, the partial word is discarded (same effect as flush) and o_timeout pulses high for exactly 1 cycle.
  - The counter is held at 0 while o_busy=0.
  - Timeout coincident with i_sym_valid: the symbol is accepted and the counter restarts, so no timeout occurs.
- Undefined:
  - No idle counter is built and o_timeout is tied to 0.
  - A partial word waits indefinitely.

Test Plan:
- Defaults, ready=1: symbols 0x11,0x22,0x33,0x44 on consecutive cycles -> o_word=0x44332211, o_word_valid=1 the cycle after 0x44, cleared the following cycle; o_sym_count sequence 1,2,3,0.
- MSB_FIRST=1, same symbols -> o_word=0x11223344.
- ready=0, send 0x01..0x08 -> o_word=0x04030201 held, o_overflow=1 after 0x08, second word lost; pulse i_clear_err -> o_overflow=0.
- Send 0xAA,0xBB, pulse i_flush, send 0x01..0x04 -> o_word=0x04030201, with no 0xAA/0xBB content; o_busy=0 right after flush.
- Completion with o_word_valid=1 and i_word_ready=1 in the same cycle -> new word loaded, o_word_valid stays 1, o_overflow=0; reset asserted after 2 symbols -> all outputs 0 immediately, and the next 4 symbols form a clean word.
- RX_ASM_TIMEOUT_EN, TIMEOUT_CYCLES=16: 1 symbol then 16 idle cycles -> o_timeout pulses once, o_sym_count=0; a symbol arriving at idle cycle 15 -> no timeout.
